uart_rx_fifo: RTL

- Receive-side byte buffer that sits directly downstream of the UART receiver.
- Captures each received byte, qualified by the receiver's one-cycle done strobe, into a circular buffer.
- Presents the oldest byte first-word-fall-through to the MMIO read logic.
- Gives the CPU slack between byte arrivals; reports occupancy and full/empty status.

---
 rtl/uart_rx_fifo.sv | 86 ++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// Receive-side FIFO behind the UART receiver: first-word-fall-through head, registered occupancy flags.
// Optional sticky overrun flag on dropped bytes is enabled by defining UART_RX_FIFO_OVERRUN_EN.
module uart_rx_fifo #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr,
    input  logic [DATA_W-1:0] w_data,
    input  logic              rd,
`ifdef UART_RX_FIFO_OVERRUN_EN
    input  logic              clr_overrun,
    output logic              overrun,
`endif
    output logic [DATA_W-1:0] r_data,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   level
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] w_ptr;
    logic [ADDR_W-1:0] r_ptr;
    logic              do_wr_c;
    logic              do_rd_c;

    // A write into a full FIFO only proceeds when the head is popped on the same edge.
    assign do_wr_c = wr && (!full || rd);
    assign do_rd_c = rd && !empty;
    assign r_data  = mem[r_ptr];

    // Storage is deliberately not reset; empty qualifies r_data.
    always_ff @(posedge clk) begin
        if (do_wr_c) begin
            mem[w_ptr] <= w_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_ptr <= '0;
            r_ptr <= '0;
            empty <= 1'b1;
            full  <= 1'b0;
            level <= '0;
        end else begin
            case ({do_wr_c, do_rd_c})
                2'b10: begin
                    w_ptr <= w_ptr + ADDR_W'(1);
                    empty <= 1'b0;
                    full  <= ((w_ptr + ADDR_W'(1)) == r_ptr);
                    level <= level + (ADDR_W+1)'(1);
                end
                2'b01: begin
                    r_ptr <= r_ptr + ADDR_W'(1);
                    full  <= 1'b0;
                    empty <= ((r_ptr + ADDR_W'(1)) == w_ptr);
                    level <= level - (ADDR_W+1)'(1);
                end
                2'b11: begin
                    w_ptr <= w_ptr + ADDR_W'(1);
                    r_ptr <= r_ptr + ADDR_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

`ifdef UART_RX_FIFO_OVERRUN_EN
    // Sticky drop indicator; a drop on the same edge as a clear wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overrun <= 1'b0;
        end else if (wr && full && !rd) begin
            overrun <= 1'b1;
        end else if (clr_overrun) begin
            overrun <= 1'b0;
        end
    end
`endif

endmodule
